// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: res = op1 - op2, one bit per clock LSB first,
// driven by a start/busy/done handshake with a single borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             bo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, busy_q, done_q, bo_q;

  logic             diff_d, br_d;
  logic [WIDTH-1:0] r_d;

  // Half-subtractor cell plus borrow-in for the current LSB.
  always_comb begin
    diff_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    r_d    = {diff_d, r_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // res/bo deliberately left holding the previous result
            a_q     <= op1;
            b_q     <= op2;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= r_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= r_d;
            bo_q    <= br_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign bo   = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=13.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  logic start8, start13;
  logic [7:0]  op1_8, op2_8, res8;
  logic [12:0] op1_13, op2_13, res13;
  logic busy8, done8, bo8, busy13, done13, bo13;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op1(op1_8), .op2(op2_8),
    .busy(busy8), .done(done8), .res(res8), .bo(bo8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .op1(op1_13), .op2(op2_13),
    .busy(busy13), .done(done13), .res(res13), .bo(bo13)
  );

  // One-cycle start pulse; returns at the negedge just after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; op1_8 = a; op2_8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen, and busy cycles observed.
  task automatic wait_done8(output int cyc, output int busyc);
    cyc = 0; busyc = 0;
    while (cyc < 40 && !done8) begin
      if (busy8) busyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 0; start13 = 0;
    op1_8 = '0; op2_8 = '0; op1_13 = '0; op2_13 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy8, done8, res8, bo8} !== 11'b0) begin
      bad++;
      $display("FAIL reset8: busy=%b done=%b res=%h bo=%b want all 0", busy8, done8, res8, bo8);
    end
    total++;
    if ({busy13, done13, res13, bo13} !== 16'b0) begin
      bad++;
      $display("FAIL reset13: busy=%b done=%b res=%h bo=%b want all 0", busy13, done13, res13, bo13);
    end
  endtask

  task automatic test_basic;
    int cyc, busyc;
    start_op8(8'd100, 8'd37);
    wait_done8(cyc, busyc);
    total++;
    if (cyc != 8 || busyc != 8) begin
      bad++;
      $display("FAIL basic_latency: done_cyc=%0d busy_cyc=%0d want 8/8", cyc, busyc);
    end
    total++;
    if (res8 !== 8'd63 || bo8 !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: res=%0d bo=%b want 63/0", res8, bo8);
    end
    @(negedge clk);
    total++;
    if (done8 !== 1'b0 || res8 !== 8'd63) begin
      bad++;
      $display("FAIL done_pulse: done=%b res=%0d want 0/63", done8, res8);
    end
  endtask

  task automatic test_underflow;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [8:0] ve [3];
    int cyc, busyc;
    va = '{8'd5, 8'd0, 8'd255};
    vb = '{8'd9, 8'd1, 8'd255};
    ve = '{9'h1FC, 9'h1FF, 9'h000};
    for (int i = 0; i < 3; i++) begin
      start_op8(va[i], vb[i]);
      wait_done8(cyc, busyc);
      total++;
      if (cyc != 8 || {bo8, res8} !== ve[i]) begin
        bad++;
        $display("FAIL underflow[%0d]: cyc=%0d bo,res=%h want 8/%h", i, cyc, {bo8, res8}, ve[i]);
      end
    end
  endtask

  task automatic test_ignore_busy;
    int cyc, busyc, extra;
    start_op8(8'd200, 8'd100);
    repeat (2) @(negedge clk);
    start8 = 1'b1; op1_8 = 8'd1; op2_8 = 8'd2;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(cyc, busyc);
    total++;
    if (cyc != 5 || res8 !== 8'd100 || bo8 !== 1'b0) begin
      bad++;
      $display("FAIL ignore_busy: cyc=%0d res=%0d bo=%b want 5/100/0", cyc, res8, bo8);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_busy_extra: extra_active=%0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, n;
    logic [8:0] r1, r2;
    d1 = -1; d2 = -1; n = 0; r1 = '0; r2 = '0;
    @(negedge clk);
    start8 = 1'b1; op1_8 = 8'd10; op2_8 = 8'd3;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (done8) begin
        if (n == 0) begin
          d1 = c; r1 = {bo8, res8};
          op1_8 = 8'd3; op2_8 = 8'd10;
        end else if (n == 1) begin
          d2 = c; r2 = {bo8, res8};
          start8 = 1'b0;
        end
        n++;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    total++;
    if (d1 != 8 || r1 !== 9'h007) begin
      bad++;
      $display("FAIL b2b_first: cyc=%0d bo,res=%h want 8/007", d1, r1);
    end
    total++;
    if (d2 != 17 || r2 !== 9'h1F9 || n != 2) begin
      bad++;
      $display("FAIL b2b_second: cyc=%0d bo,res=%h dones=%0d want 17/1f9/2", d2, r2, n);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc, busyc, extra;
    start_op8(8'd100, 8'd37);
    wait_done8(cyc, busyc);
    total++;
    if (res8 !== 8'd63) begin
      bad++;
      $display("FAIL abort_pre: res=%0d want 63", res8);
    end
    start_op8(8'd50, 8'd20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy8, done8, res8, bo8} !== 11'b0) begin
      bad++;
      $display("FAIL abort_state: busy=%b done=%b res=%0d bo=%b want 0", busy8, done8, res8, bo8);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL abort_no_done: active=%0d want 0", extra);
    end
    start_op8(8'd50, 8'd20);
    wait_done8(cyc, busyc);
    total++;
    if (cyc != 8 || res8 !== 8'd30 || bo8 !== 1'b0) begin
      bad++;
      $display("FAIL abort_recover: cyc=%0d res=%0d bo=%b want 8/30/0", cyc, res8, bo8);
    end
  endtask

  task automatic test_random8;
    logic [7:0] a, b;
    logic [8:0] exp;
    int cyc, busyc;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp = {1'b0, a} - {1'b0, b};
      start_op8(a, b);
      wait_done8(cyc, busyc);
      total++;
      if (cyc != 8 || {bo8, res8} !== exp) begin
        bad++;
        $display("FAIL rand8 a=%h b=%h: cyc=%0d got=%h want 8/%h", a, b, cyc, {bo8, res8}, exp);
      end
    end
  endtask

  task automatic test_random13;
    logic [12:0] a, b;
    logic [13:0] exp;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      a = 13'($urandom); b = 13'($urandom);
      if (i == 0) begin a = 13'd0; b = 13'h1FFF; end
      exp = {1'b0, a} - {1'b0, b};
      @(negedge clk);
      start13 = 1'b1; op1_13 = a; op2_13 = b;
      @(negedge clk);
      start13 = 1'b0;
      cyc = 0;
      while (cyc < 40 && !done13) begin
        @(negedge clk);
        cyc++;
      end
      total++;
      if (cyc != 13 || {bo13, res13} !== exp) begin
        bad++;
        $display("FAIL rand13 a=%h b=%h: cyc=%0d got=%h want 13/%h", a, b, cyc, {bo13, res13}, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid_run;
    test_random8;
    test_random13;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
